// File: rtl/apb_timer_slave.sv
// APB3 completer with a register bank and a 32-bit reloading down-counter timer.
// Optional PRESCALE register (offset 0x18) is enabled by defining APB_TIMER_PRESCALE_EN.
module apb_timer_slave #(
    parameter int          ADDR_W      = 20,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h5449_0001
) (
    input  logic              i_pclk,
    input  logic              i_presetn,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic [31:0]       i_pwdata,
    output logic [31:0]       o_prdata,
    output logic              o_pready,
    output logic              o_pslverr,
    output logic              o_irq
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wait;
    logic        w_access;
    logic        w_ready;
    logic        w_mapped;
    logic        w_ro;
    logic        w_err;
    logic        w_wr;
    logic        w_tick;
    logic        w_expire;
    logic [5:0]  w_off;
    logic [31:0] w_rdata;

    logic        r_en;
    logic        r_irq_en;
    logic        r_oneshot;
    logic [31:0] r_load;
    logic [31:0] r_value;
    logic        r_exp;
    logic [31:0] r_scratch;
    logic        r_irq;
    logic        w_unused_addr;

    assign w_off         = i_paddr[7:2];
    assign w_unused_addr = ^{i_paddr[ADDR_W-1:8], i_paddr[1:0]};

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // An access phase is only honoured after a setup phase was seen, so a
    // transfer cut by reset cannot complete on stale PSEL/PENABLE.
    always_comb begin
        w_next   = S_IDLE;
        w_access = 1'b0;
        case (r_state)
            S_SETUP, S_ACCESS: w_access = i_psel & i_penable;
            default:           w_access = 1'b0;
        endcase
        w_ready = w_access && (r_wait == WS);
        if (w_access && !w_ready)      w_next = S_ACCESS;
        else if (i_psel && !i_penable) w_next = S_SETUP;
    end

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn)              r_wait <= '0;
        else if (w_access && !w_ready) r_wait <= r_wait + 4'd1;
        else                         r_wait <= '0;
    end

`ifdef APB_TIMER_PRESCALE_EN
    logic [15:0] r_psc;
    logic [15:0] r_psc_cnt;
    logic        w_psc_clr;
`endif

    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        w_ro     = 1'b0;
        case (w_off)
            6'h00: w_rdata = {29'd0, r_oneshot, r_irq_en, r_en};
            6'h01: w_rdata = r_load;
            6'h02: begin w_rdata = r_value;  w_ro = 1'b1; end
            6'h03: w_rdata = {31'd0, r_exp};
            6'h04: w_rdata = r_scratch;
            6'h05: begin w_rdata = ID_VALUE; w_ro = 1'b1; end
`ifdef APB_TIMER_PRESCALE_EN
            6'h06: w_rdata = {16'd0, r_psc};
`endif
            default: w_mapped = 1'b0;
        endcase
    end

    assign w_err     = !w_mapped || (i_pwrite && w_ro);
    assign w_wr      = w_ready && i_pwrite && !w_err;
    assign o_pready  = w_ready;
    assign o_pslverr = w_ready && w_err;
    assign o_prdata  = (w_access && !w_err) ? w_rdata : '0;
    assign o_irq     = r_irq;

`ifdef APB_TIMER_PRESCALE_EN
    assign w_psc_clr = w_wr && ((w_off == 6'h06) || (w_off == 6'h00 && !r_en && i_pwdata[0]));
    assign w_tick    = r_en && (r_psc_cnt == r_psc);

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_psc     <= '0;
            r_psc_cnt <= '0;
        end else begin
            if (w_wr && w_off == 6'h06) r_psc <= i_pwdata[15:0];
            if (w_psc_clr)   r_psc_cnt <= '0;
            else if (w_tick) r_psc_cnt <= '0;
            else if (r_en)   r_psc_cnt <= r_psc_cnt + 16'd1;
        end
    end
`else
    assign w_tick = r_en;
`endif

    assign w_expire = w_tick && (r_value == '0);

    // Bus writes are placed after the timer update so they take precedence
    // for EN and VALUE; EXP set by expiry beats a simultaneous clear.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_en      <= 1'b0;
            r_irq_en  <= 1'b0;
            r_oneshot <= 1'b0;
            r_load    <= '0;
            r_value   <= '0;
            r_exp     <= 1'b0;
            r_scratch <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_expire) begin
                r_exp   <= 1'b1;
                r_value <= r_load;
                if (r_oneshot) r_en <= 1'b0;
            end else if (w_tick) begin
                r_value <= r_value - 32'd1;
            end
            if (w_wr) begin
                case (w_off)
                    6'h00: {r_oneshot, r_irq_en, r_en} <= i_pwdata[2:0];
                    6'h01: begin
                        r_load  <= i_pwdata;
                        r_value <= i_pwdata;
                    end
                    6'h03: if (i_pwdata[0] && !w_expire) r_exp <= 1'b0;
                    6'h04: r_scratch <= i_pwdata;
                    default: ;
                endcase
            end
            r_irq <= r_exp & r_irq_en;
        end
    end
endmodule

// File: tb/tb_apb_timer_slave.sv
// Randomized self-checking bench for apb_timer_slave against a register-level model.
module tb_apb_timer_slave;
    localparam int          WS = 3;
    localparam logic [31:0] ID = 32'h5449_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [19:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_en, m_ie, m_os, m_exp, m_irq;
    logic [31:0] m_load, m_value, m_scr;

    always #5 clk = ~clk;

    apb_timer_slave #(.ADDR_W(20), .WAIT_STATES(WS), .ID_VALUE(ID)) dut (
        .i_pclk(clk), .i_presetn(rst_n), .i_psel(psel), .i_penable(penable),
        .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
        .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr), .o_irq(irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_os = 0; m_exp = 0; m_irq = 0;
        m_load = '0; m_value = '0; m_scr = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [5:0] off);
        case (off)
            6'd0: return {29'd0, m_os, m_ie, m_en};
            6'd1: return m_load;
            6'd2: return m_value;
            6'd3: return {31'd0, m_exp};
            6'd4: return m_scr;
            6'd5: return ID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_err(input bit wr, input logic [5:0] off);
        return (off > 6'd5) || (wr && (off == 6'd2 || off == 6'd5));
    endfunction

    // One clock of the timer as described by the register rules.
    task automatic model_step(input bit commit, input logic [5:0] off, input logic [31:0] wd);
        bit          n_en, n_ie, n_os, n_exp, expired;
        logic [31:0] n_load, n_value, n_scr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n_en = m_en; n_ie = m_ie; n_os = m_os; n_exp = m_exp;
        n_load = m_load; n_value = m_value; n_scr = m_scr;
        expired = m_en && (m_value == 0);
        if (expired) begin
            n_exp = 1; n_value = m_load;
            if (m_os) n_en = 0;
        end else if (m_en) begin
            n_value = m_value - 1;
        end
        if (commit) begin
            case (off)
                6'd0: begin n_en = wd[0]; n_ie = wd[1]; n_os = wd[2]; end
                6'd1: begin n_load = wd; n_value = wd; end
                6'd3: n_exp = expired ? 1'b1 : (wd[0] ? 1'b0 : m_exp);
                6'd4: n_scr = wd;
                default: ;
            endcase
        end
        m_irq = m_exp & m_ie;
        m_en = n_en; m_ie = n_ie; m_os = n_os; m_exp = n_exp;
        m_load = n_load; m_value = n_value; m_scr = n_scr;
    endtask

    task automatic edge_step(input bit commit, input logic [5:0] off, input logic [31:0] wd);
        @(posedge clk);
        model_step(commit, off, wd);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            psel = 0; penable = 0;
            @(negedge clk);
            check_eq("idle_irq", irq, m_irq);
            check_eq("idle_pready", pready, 0);
            check_eq("idle_prdata", prdata, 0);
            edge_step(0, 6'd0, 32'd0);
        end
    endtask

    task automatic apb(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
        logic [5:0] off;
        bit         e;
        off = addr[7:2];
        e   = m_err(wr, off);
        rd  = '0;
        psel = 1; penable = 0; pwrite = wr; paddr = {12'd0, addr}; pwdata = wd;
        @(negedge clk);
        check_eq("setup_pready", pready, 0);
        check_eq("setup_prdata", prdata, 0);
        check_eq("setup_irq", irq, m_irq);
        edge_step(0, off, wd);
        penable = 1;
        for (int k = 0; k <= WS; k++) begin
            @(negedge clk);
            check_eq("access_pready", pready, 32'(k == WS));
            check_eq("access_irq", irq, m_irq);
            if (k == WS) begin
                check_eq("pslverr", pslverr, 32'(e));
                if (!wr) check_eq("prdata", prdata, e ? 32'd0 : m_read(off));
                rd = prdata;
            end
            edge_step(k == WS && wr && !e, off, wd);
        end
        psel = 0; penable = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  addrs [8];
        int          guard;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40};
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_prdata", prdata, 0);
        check_eq("rst_pready", pready, 0);
        check_eq("rst_pslverr", pslverr, 0);
        check_eq("rst_irq", irq, 0);
        @(posedge clk); #1 rst_n = 1;
        apb(0, 8'h14, 0, rd);
        check_eq("id", rd, ID);

        // Wait states and scratch readback
        apb(1, 8'h10, 32'hA5A5_5A5A, rd);
        apb(0, 8'h10, 0, rd);
        check_eq("scratch_rb", rd, 32'hA5A5_5A5A);

        // Error accesses
        apb(1, 8'h08, 32'h0000_1234, rd);
        apb(0, 8'h08, 0, rd);
        check_eq("value_unchanged", rd, 0);
        apb(0, 8'h40, 0, rd);
        check_eq("unmapped_rd", rd, 0);
        apb(0, 8'h18, 0, rd);
        apb(1, 8'h14, 32'hFFFF_FFFF, rd);
        apb(0, 8'h14, 0, rd);
        check_eq("id_unchanged", rd, ID);

        // Periodic mode with interrupt, then clear
        apb(1, 8'h04, 4, rd);
        apb(1, 8'h00, 3, rd);
        idle(30);
        apb(1, 8'h0C, 1, rd);
        idle(3);

        // One-shot
        apb(1, 8'h00, 0, rd);
        apb(1, 8'h04, 2, rd);
        apb(1, 8'h00, 5, rd);
        idle(10);
        apb(0, 8'h00, 0, rd);
        check_eq("oneshot_ctrl", rd, 4);
        apb(0, 8'h08, 0, rd);
        check_eq("oneshot_value", rd, 2);
        apb(1, 8'h0C, 1, rd);
        idle(2);

        // Clear collides with expiry: commit edge lands when VALUE is 0
        apb(1, 8'h04, 9, rd);
        apb(1, 8'h00, 3, rd);
        guard = 0;
        while (!(m_en && m_value == 4) && guard < 40) begin
            idle(1);
            guard++;
        end
        if (guard >= 40) check_eq("coll_timeout", 0, 1);
        apb(1, 8'h0C, 1, rd);
        apb(0, 8'h0C, 0, rd);
        check_eq("coll_exp", rd, 1);
        apb(1, 8'h00, 0, rd);
        idle(2);

        // Reset pulse in the middle of an access phase
        psel = 1; penable = 0; pwrite = 1; paddr = 20'h10; pwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        edge_step(0, 6'd4, 32'hDEAD_BEEF);
        penable = 1;
        @(negedge clk);
        check_eq("abort_pready", pready, 0);
        edge_step(0, 6'd4, 32'hDEAD_BEEF);
        #2 rst_n = 0;
        model_reset();
        #2;
        check_eq("abort_rst_pready", pready, 0);
        check_eq("abort_rst_prdata", prdata, 0);
        check_eq("abort_rst_irq", irq, 0);
        @(posedge clk);
        #1 psel = 0; penable = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        apb(0, 8'h10, 0, rd);
        check_eq("abort_scratch", rd, 0);
        apb(0, 8'h00, 0, rd);
        check_eq("abort_ctrl", rd, 0);
        apb(0, 8'h04, 0, rd);
        check_eq("abort_load", rd, 0);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            logic [7:0]  a;
            logic [31:0] d;
            bit          w;
            a = addrs[$urandom_range(0, 7)];
            w = 1'($urandom_range(0, 1));
            case (a)
                8'h00:   d = $urandom_range(0, 7);
                8'h04:   d = $urandom_range(0, 12);
                default: d = $urandom;
            endcase
            apb(w, a, d, rd);
            idle($urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB3 completer in the FPGA fabric that answers the MSS fabric APB master (MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA in, MSSPRDATA/MSSPREADY/MSSPSLVERR out). It provides a small register bank and a 32-bit down-counting timer with reload, one-shot mode and a level interrupt toward the MSS. Configurable wait states and PSLVERR on illegal accesses exercise the master's full handshake.

## Interface
- ADDR_W, 20: PADDR width, matching MSSPADDR.
- WAIT_STATES, 0: access-phase cycles before PREADY rises (0–15).
- ID_VALUE, 32'h5449_0001: constant returned by the ID register.
- PCLK  in  1  fabric clock (FAB_CLK); all logic on rising edge.
- PRESETN  in  1  asynchronous active-low reset (M2F_RESET_N).
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_W  byte address; only PADDR[7:2] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error, valid with PREADY.
- IRQ  out  1  level interrupt, registered.

## Operation
- Register map (word offsets): 0x00 CTRL RW {bit0 EN, bit1 IRQ_EN, bit2 ONESHOT}, others read 0; 0x04 LOAD RW; 0x08 VALUE RO; 0x0C STATUS bit0 EXP, write-1-to-clear; 0x10 SCRATCH RW; 0x14 ID RO.
- Reset values: CTRL 0, LOAD 0, VALUE 0, STATUS 0, SCRATCH 0; outputs PRDATA 0, PREADY 0, PSLVERR 0, IRQ 0.
- Handshake FSM: IDLE → SETUP (PSEL & !PENABLE) → ACCESS (PSEL & PENABLE); wait counter counts in ACCESS; PREADY = 1 when counter == WAIT_STATES; return to IDLE (or SETUP if PSEL stays high with PENABLE low) next cycle.
- Write commits only on the cycle PSEL & PENABLE & PREADY, never during wait cycles.
- PRDATA: selected register value during ACCESS; 0 in IDLE/SETUP and on error.
- PSLVERR = 1 with PREADY for: unmapped offset, write to VALUE or ID. Erroring writes change no state.
- Timer: when EN = 1, VALUE decrements by 1 per tick. On tick with VALUE == 0: EXP ← 1, VALUE ← LOAD; if ONESHOT, EN ← 0.
- Write to LOAD also loads VALUE on the same commit edge (overrides that cycle's decrement).
- EN = 0: VALUE holds.
- Simultaneous expiry and STATUS W1C: set wins, EXP stays 1.
- Simultaneous expiry and CTRL write: the CTRL write value wins for EN.
- VALUE wraps never: 0 always reloads; LOAD = 0 expires every tick.
- IRQ ← EXP & IRQ_EN, one-cycle registered.
- PRESETN assertion mid-transfer: FSM to IDLE, all registers to reset values immediately; the aborted transfer has no effect.

## Timing
- WAIT_STATES = 0: transfer is 2 cycles (SETUP, ACCESS with PREADY = 1).
- WAIT_STATES = N: ACCESS lasts N+1 cycles; PREADY low for the first N.
- Read data: combinational from register state, valid while PREADY = 1.
- Read of VALUE returns the value before that edge's decrement.
- Expiry → EXP set on the tick edge; IRQ high one cycle later.
- W1C of EXP → IRQ low one cycle after the commit edge.

## Configuration
- APB_TIMER_PRESCALE_EN defined: register 0x18 PRESCALE RW (bits 15:0, reset 0); a tick occurs every PRESCALE+1 PCLK cycles; prescale counter resets when EN goes 0→1 or PRESCALE is written.
- Undefined: tick every PCLK cycle while EN = 1; offset 0x18 is unmapped (PSLVERR = 1, PRDATA 0).

## Test plan
- Reset: PRESETN low → PRDATA 0, PREADY 0, PSLVERR 0, IRQ 0; read ID → 32'h5449_0001, PSLVERR 0.
- WAIT_STATES = 3: write SCRATCH 32'hA5A5_5A5A → PREADY low 3 ACCESS cycles, high on the 4th; readback 32'hA5A5_5A5A.
- Errors: write VALUE, read offset 0x40 → PSLVERR 1 with PREADY; VALUE unchanged, PRDATA 0.
- Periodic: LOAD 4, CTRL 3'b011 → EXP set every 5 ticks, IRQ high one cycle after EXP; W1C STATUS 1 → IRQ low next cycle.
- One-shot: LOAD 2, CTRL 3'b101 → single expiry, CTRL reads 3'b100, VALUE holds 2.
- Collision: W1C STATUS on the expiry cycle → EXP remains 1; PRESETN pulse during ACCESS → no write committed, registers at reset values.
